// File: rtl/oven_setpoint_fsm.sv
// Front-panel control for the oven: debounces the four buttons, generates press and
// auto-repeat events, and runs the operator FSM that owns the temperature/time setpoints.
module oven_setpoint_fsm #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int TEMP_MIN        = 150,
    parameter int TEMP_MAX        = 550,
    parameter int TEMP_STEP       = 5,
    parameter int TEMP_DEFAULT    = 350,
    parameter int TIME_MAX        = 999,
    parameter int TIME_DEFAULT    = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_next,
    input  logic       btn_cancel,
    input  logic       bake_done,
    output logic [1:0] state,
    output logic [9:0] inputTemp,
    output logic [9:0] timerVal,
    output logic [9:0] edit_val
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HD_W = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HD_W-1:0] HOLD_V  = HD_W'(HOLD_CYCLES);
    localparam logic [HD_W-1:0] WRAP_V  = HD_W'(HOLD_CYCLES + REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SET_TEMP = 2'd1,
        S_BAKE     = 2'd2,
        S_SET_TIME = 2'd3
    } state_t;

    // Button order in all vectors: 0=up, 1=down, 2=next, 3=cancel
    logic [3:0]      raw;
    logic [3:0]      sync1_q, sync2_q, deb_q, deb_prev_q, ev_q;
    logic [DB_W-1:0] db_cnt_q [4];
    logic [HD_W-1:0] hold_cnt_q [2];
    logic [HD_W-1:0] hold_cnt_d [2];
    logic [1:0]      rep_d;

    assign raw = {btn_cancel, btn_next, btn_down, btn_up};

    // Hold count 0 is the press itself; repeats fire when the count lands on HOLD_V,
    // and the counter folds back to HOLD_V every REPEAT_CYCLES.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            hold_cnt_d[i] = hold_cnt_q[i];
            rep_d[i]      = 1'b0;
            if (!deb_q[i]) begin
                hold_cnt_d[i] = '0;
            end else if (deb_prev_q[i]) begin
                hold_cnt_d[i] = (hold_cnt_q[i] == WRAP_V) ? HOLD_V : hold_cnt_q[i] + 1'b1;
                rep_d[i]      = (hold_cnt_d[i] == HOLD_V);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            ev_q       <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
            for (int i = 0; i < 2; i++) hold_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        deb_q[i]    <= ~deb_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                hold_cnt_q[i] <= hold_cnt_d[i];
                ev_q[i]       <= (deb_q[i] & ~deb_prev_q[i]) | rep_d[i];
            end
            for (int i = 2; i < 4; i++) ev_q[i] <= deb_q[i] & ~deb_prev_q[i];
        end
    end

    // Arbitration: cancel beats next beats up/down; simultaneous up+down cancel out.
    logic cancel_ev, next_ev, up_ev, down_ev;
    assign cancel_ev = ev_q[3];
    assign next_ev   = ev_q[2] & ~ev_q[3];
    assign up_ev     = ev_q[0] & ~ev_q[1] & ~ev_q[2] & ~ev_q[3];
    assign down_ev   = ev_q[1] & ~ev_q[0] & ~ev_q[2] & ~ev_q[3];

    state_t     state_q;
    logic [9:0] temp_q, time_q;
    logic [10:0] temp_up_d, temp_dn_d, time_up_d, time_dn_d;

    always_comb begin
        temp_up_d = {1'b0, temp_q} + 11'(TEMP_STEP);
        if (temp_up_d > 11'(TEMP_MAX)) temp_up_d = 11'(TEMP_MAX);
        temp_dn_d = {1'b0, temp_q} - 11'(TEMP_STEP);
        if ({1'b0, temp_q} < 11'(TEMP_MIN + TEMP_STEP)) temp_dn_d = 11'(TEMP_MIN);
        time_up_d = {1'b0, time_q} + 11'd1;
        if (time_up_d > 11'(TIME_MAX)) time_up_d = 11'(TIME_MAX);
        time_dn_d = {1'b0, time_q} - 11'd1;
        if (time_q <= 10'd1) time_dn_d = 11'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            temp_q  <= 10'(TEMP_DEFAULT);
            time_q  <= 10'(TIME_DEFAULT);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (next_ev) state_q <= S_SET_TEMP;
                end
                S_SET_TEMP: begin
                    if (cancel_ev)    state_q <= S_IDLE;
                    else if (next_ev) state_q <= S_SET_TIME;
                    else if (up_ev)   temp_q  <= temp_up_d[9:0];
                    else if (down_ev) temp_q  <= temp_dn_d[9:0];
                end
                S_SET_TIME: begin
                    if (cancel_ev)    state_q <= S_IDLE;
                    else if (next_ev) state_q <= S_BAKE;
                    else if (up_ev)   time_q  <= time_up_d[9:0];
                    else if (down_ev) time_q  <= time_dn_d[9:0];
                end
                S_BAKE: begin
                    if (cancel_ev || bake_done) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state     = state_q;
    assign inputTemp = temp_q;
    assign timerVal  = time_q;

    always_comb begin
        case (state_q)
            S_SET_TEMP: edit_val = temp_q;
            S_SET_TIME: edit_val = time_q;
            default:    edit_val = 10'd0;
        endcase
    end

endmodule
